// File: rtl/sr_latch_driver.sv
// sr_latch_driver: synchronises and debounces set/reset buttons and sequences gated-SR latch writes.
// Optional pending-request storage is enabled by defining SR_LATCH_DRIVER_PENDING_EN.
module sr_latch_driver #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_rst,
  output logic S,
  output logic R,
  output logic C,
  output logic busy,
  output logic drop
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_SETUP  = 2'd1;
  localparam logic [1:0]  ST_STROBE = 2'd2;
  localparam logic [1:0]  ST_HOLD   = 2'd3;
  localparam logic [15:0] LP_DB_LAST    = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  LP_PULSE_LAST = 8'(PULSE_CYCLES - 1);

  // Channel 0 is the set button, channel 1 the reset button.
  logic [1:0]  w_raw;
  logic [1:0]  r_sync1;
  logic [1:0]  r_sync2;
  logic [1:0]  r_db;
  logic [1:0]  r_db_d;
  logic [15:0] r_dcnt [2];
  logic [1:0]  w_rise;
  logic        w_req_set;
  logic        w_req_rst;

  assign w_raw = {btn_rst, btn_set};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      for (int i = 0; i < 2; i++) r_dcnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] >= LP_DB_LAST) begin
          r_db[i]   <= ~r_db[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 16'd1;
        end
      end
    end
  end

  assign w_rise    = r_db & ~r_db_d;
  assign w_req_set = w_rise[0];
  assign w_req_rst = w_rise[1];

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_sel_set;
  logic       w_sel_set_nxt;
  logic [7:0] r_pcnt;
  logic       w_want_set;
  logic       w_want_rst;
  logic       w_drop;

`ifdef SR_LATCH_DRIVER_PENDING_EN
  logic r_pend_set;
  logic r_pend_rst;
  logic w_pend_set_nxt;
  logic w_pend_rst_nxt;

  assign w_want_set = w_req_set | r_pend_set;
  assign w_want_rst = w_req_rst | r_pend_rst;

  // The request type served from IDLE consumes its flag; the other type is parked or dropped.
  always_comb begin
    w_pend_set_nxt = r_pend_set;
    w_pend_rst_nxt = r_pend_rst;
    w_drop         = 1'b0;
    if (r_state == ST_IDLE && w_want_rst) begin
      w_pend_rst_nxt = 1'b0;
      if (w_req_rst && r_pend_rst) w_drop = 1'b1;
      if (w_req_set) begin
        if (r_pend_set) w_drop = 1'b1;
        else            w_pend_set_nxt = 1'b1;
      end
    end else if (r_state == ST_IDLE && w_want_set) begin
      w_pend_set_nxt = 1'b0;
      if (w_req_set && r_pend_set) w_drop = 1'b1;
    end else if (r_state != ST_IDLE) begin
      if (w_req_rst) begin
        if (r_pend_rst) w_drop = 1'b1;
        else            w_pend_rst_nxt = 1'b1;
      end
      if (w_req_set) begin
        if (r_pend_set) w_drop = 1'b1;
        else            w_pend_set_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_set <= 1'b0;
      r_pend_rst <= 1'b0;
    end else begin
      r_pend_set <= w_pend_set_nxt;
      r_pend_rst <= w_pend_rst_nxt;
    end
  end
`else
  assign w_want_set = w_req_set;
  assign w_want_rst = w_req_rst;

  always_comb begin
    w_drop = 1'b0;
    if (r_state == ST_IDLE) w_drop = w_req_rst & w_req_set;
    else                    w_drop = w_req_rst | w_req_set;
  end
`endif

  // NOTE: every always_comb output is given a default first, so no latch can be inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_set_nxt = r_sel_set;
    case (r_state)
      ST_IDLE: begin
        if (w_want_rst) begin
          w_state_nxt   = ST_SETUP;
          w_sel_set_nxt = 1'b0;
        end else if (w_want_set) begin
          w_state_nxt   = ST_SETUP;
          w_sel_set_nxt = 1'b1;
        end
      end
      ST_SETUP:  w_state_nxt = ST_STROBE;
      ST_STROBE: if (r_pcnt >= LP_PULSE_LAST) w_state_nxt = ST_HOLD;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so S/R/C change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sel_set <= 1'b0;
      r_pcnt    <= '0;
      S         <= 1'b0;
      R         <= 1'b0;
      C         <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel_set <= w_sel_set_nxt;
      if (r_state == ST_STROBE) begin
        if (r_pcnt != 8'hFF) r_pcnt <= r_pcnt + 8'd1;
      end else begin
        r_pcnt <= '0;
      end
      S <= (w_state_nxt != ST_IDLE) &  w_sel_set_nxt;
      R <= (w_state_nxt != ST_IDLE) & ~w_sel_set_nxt;
      C <= (w_state_nxt == ST_STROBE);
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign drop = w_drop;

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Upstream command stage for the gated SR latch. Synchronises and debounces two raw set/reset buttons and turns each debounced press into one well-formed latch write: `S` or `R` is set up first, then gate `C` is strobed, then `S`/`R` is held. `S` and `R` are never high together, and `C` is never high while `S` and `R` are both low. Outputs drive the latch's `S`, `R` and `C` inputs directly.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised cycles required before a debounced level changes; legal range 1..65535.
- `PULSE_CYCLES`, default 2: width of the `C` strobe in clock cycles; legal range 1..255.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn_set`  in  1  raw set button; asynchronous and may bounce.
- `btn_rst`  in  1  raw reset button; asynchronous and may bounce.
- `S`  out  1  latch set input; registered.
- `R`  out  1  latch reset input; registered.
- `C`  out  1  latch gate/enable; registered.
- `busy`  out  1  high while a write sequence is in progress.
- `drop`  out  1  one-cycle pulse when a request is discarded.

## Operation
- Each button passes through a 2-flop synchroniser, then a debouncer.
- Debouncer:
  - Holds a level `db_x` and a counter.
  - The counter clears whenever the synchronised input equals `db_x`. Otherwise it increments.
  - When the counter reaches `DEBOUNCE_CYCLES`, `db_x` flips and the counter clears.
- A request `req_x` is the rising edge of `db_x`. Falling edges generate nothing.
- FSM states:
  - IDLE: `S`=`R`=`C`=0.
  - SETUP: selected `S` or `R`=1, `C`=0, 1 cycle.
  - STROBE: selected `S`/`R`=1, `C`=1, `PULSE_CYCLES` cycles.
  - HOLD: selected `S`/`R`=1, `C`=0, 1 cycle.
  - After HOLD, the FSM always returns to IDLE for at least 1 cycle.
- Transitions:
  - IDLE→SETUP on any request, whether pending or new.
  - SETUP→STROBE.
  - STROBE→HOLD when the pulse counter reaches `PULSE_CYCLES`-1.
  - HOLD→IDLE.
- `busy`=1 in SETUP, STROBE and HOLD.
- Priority: reset beats set. If `req_set` and `req_rst` arrive in the same IDLE cycle, the reset write is served first.
- Pending behaviour (requests arriving while busy, and the losing simultaneous request) is set by the macro in Configuration.
- Reset (asynchronous, any time, including mid-sequence):
  - All outputs go to 0 immediately: `S`=`R`=`C`=`busy`=`drop`=0.
  - FSM goes to IDLE.
  - Synchronisers, `db_x`, counters and pending flags clear.
  - After release, a button still held high produces a fresh request once it is debounced.

## Timing
- Latency from raw button edge to `S`/`R` high:
  - Raw input stable from cycle 0: `db_x` rises at edge 2+`DEBOUNCE_CYCLES`.
  - `S`/`R` rises at the next edge (SETUP).
- `C` rises exactly 1 cycle after `S`/`R` rises.
- `C` stays high for `PULSE_CYCLES` cycles.
- `S`/`R` falls 1 cycle after `C` falls.
- Sequence length: `PULSE_CYCLES`+2 cycles busy, plus a 1-cycle IDLE gap.
- Minimum spacing between write starts: `PULSE_CYCLES`+3 cycles.
- `drop` is asserted in the same cycle as the discarded request's edge.
- Counters saturate at their limits and never wrap.
- A bounce shorter than `DEBOUNCE_CYCLES` never changes `db_x`.

## Configuration
- Macro: `SR_LATCH_DRIVER_PENDING_EN`.
- Defined:
  - One pending flag per request type.
  - A request arriving while busy, or losing the simultaneous-arrival tie, sets its flag.
  - In IDLE, pending reset is served before pending set.
  - `drop` pulses only when a request of a type whose flag is already set arrives.
- Undefined:
  - No pending storage.
  - Any request while busy is discarded with a `drop` pulse.
  - On simultaneous arrival, the reset is served and the set is discarded with a `drop` pulse.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4 and `PULSE_CYCLES`=2.
- Reset: assert `rst` mid-STROBE -> `S`, `R`, `C` and `busy` are 0 within the same cycle with no clock needed; after release, FSM is in IDLE and no spurious write occurs with buttons low.
- Clean set press: `btn_set` goes 0→1 at cycle 0 and is held -> `S`=1 at cycle 7; `C`=1 at cycles 8–9; `S`=1 through cycle 10; `S`=0 at cycle 11; `busy`=1 for cycles 7–10; `R`=0 throughout.
- Bounce rejection: `btn_set` toggles every 2 cycles for 20 cycles, then stays 0 -> `db_set` never rises; no `S`, `C` or `drop` activity.
- Simultaneous press: both buttons rise in the same cycle.
  - With macro: `R` write completes, 1 IDLE cycle follows, then the `S` write runs; `drop`=0.
  - Without macro: only the `R` write occurs; `drop` pulses once.
- Request while busy: a second debounced set edge arrives during STROBE.
  - With macro: a second `S` write starts after the IDLE gap.
  - Without macro: `drop`=1 for 1 cycle and no second write.
- Invariant check: across random button stimulus (10k cycles) -> never `S`&`R`; never `C` with `S`=`R`=0; `C` is always preceded by exactly 1 setup cycle.
